// File: rtl/cm3_adc_seq.sv
// Paces XADC conversions with a programmable divider and reads one or two results over DRP.
// Packs the result into dout and pulses dout_vld one cycle after the final DRP ready.
module cm3_adc_seq #(
  parameter logic [6:0]  CH0_ADDR = 7'h03,
  parameter logic [6:0]  CH1_ADDR = 7'h1C,
  parameter int unsigned TIMEOUT  = 1024,
  parameter logic [15:0] MIN_DIV  = 16'd2
) (
  input  logic        hclk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        double,
  input  logic [15:0] div,
  output logic [23:0] dout,
  output logic        dout_vld,
  output logic        overrun,
  output logic        timeout,
  output logic        convst,
  input  logic        eoc,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [6:0]  drp_daddr,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, START, WAIT_EOC, RD0, WAIT0, RD1, WAIT1, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   per_q, per_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [11:0]   ch0_q, ch0_d;
  logic [23:0]   dout_q, dout_d;
  logic [6:0]    daddr_q, daddr_d;
  logic          dbl_q, dbl_d;
  logic          abort_q, abort_d;

  logic [15:0]   div_eff;
  logic [15:0]   per_cur;
  logic          tick;
  logic          abort_now;
  logic          in_wait_q, in_wait_d;

  // The period is latched at each wrap so a div change only lands on the next period.
  always_comb begin
    div_eff = (div < MIN_DIV) ? MIN_DIV : div;
    per_cur = (cnt_q == 16'd0) ? div_eff : per_q;
    tick    = enable && (cnt_q == (per_cur - 16'd1));
    cnt_d   = '0;
    per_d   = '0;
    if (enable) begin
      cnt_d = tick ? 16'd0 : (cnt_q + 16'd1);
      per_d = per_cur;
    end
  end

  always_comb begin
    state_d   = state_q;
    ch0_d     = ch0_q;
    dout_d    = dout_q;
    daddr_d   = daddr_q;
    dbl_d     = dbl_q;
    abort_d   = abort_q;
    abort_now = abort_q || !enable;
    convst    = 1'b0;
    drp_den   = 1'b0;
    dout_vld  = 1'b0;
    timeout   = 1'b0;
    overrun   = tick && (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (tick) state_d = START;
      end
      START: begin
        convst  = 1'b1;
        dbl_d   = double;
        state_d = enable ? WAIT_EOC : IDLE;
      end
      WAIT_EOC: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (eoc) begin
          state_d = RD0;
          daddr_d = CH0_ADDR;
        end else if (timer_q == TMAX) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      RD0: begin
        drp_den = 1'b1;
        abort_d = !enable;
        state_d = WAIT0;
      end
      WAIT0: begin
        abort_d = abort_now;
        // A read already issued must complete even after enable drops.
        if (drp_drdy) begin
          ch0_d = drp_do[15:4];
          if (abort_now) begin
            state_d = IDLE;
          end else if (dbl_q) begin
            state_d = RD1;
            daddr_d = CH1_ADDR;
          end else begin
            state_d = DONE;
            dout_d  = {12'h000, drp_do[15:4]};
          end
        end else if (timer_q == TMAX) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      RD1: begin
        drp_den = 1'b1;
        abort_d = abort_now;
        state_d = WAIT1;
      end
      WAIT1: begin
        abort_d = abort_now;
        if (drp_drdy) begin
          if (abort_now) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
            dout_d  = {drp_do[15:4], ch0_q};
          end
        end else if (timer_q == TMAX) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      DONE: begin
        dout_vld = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_wait_q = (state_q == WAIT_EOC) || (state_q == WAIT0) || (state_q == WAIT1);
    in_wait_d = (state_d == WAIT_EOC) || (state_d == WAIT0) || (state_d == WAIT1);
    timer_d   = timer_q;
    if (in_wait_d && (state_d != state_q)) begin
      timer_d = '0;
    end else if (in_wait_q) begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_ff @(posedge hclk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      timer_q <= '0;
      ch0_q   <= '0;
      dout_q  <= '0;
      daddr_q <= '0;
      dbl_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      timer_q <= timer_d;
      ch0_q   <= ch0_d;
      dout_q  <= dout_d;
      daddr_q <= daddr_d;
      dbl_q   <= dbl_d;
      abort_q <= abort_d;
    end
  end

  assign dout      = dout_q;
  assign drp_daddr = daddr_q;
  assign drp_dwe   = 1'b0;

endmodule
